// File: rtl/cnn_batch_scheduler_if.sv
// Engine control and result stream between cnn_batch_scheduler (master) and its engine/consumer (slave).
interface cnn_batch_scheduler_if #(
  parameter int IDX_W = 5,
  parameter int CLS_W = 4
);
  logic             eng_resetn;
  logic             eng_start;
  logic [IDX_W-1:0] eng_image_index;
  logic             eng_done;
  logic [CLS_W-1:0] eng_predicted_class;
  logic             res_valid;
  logic             res_ready;
  logic [IDX_W-1:0] res_index;
  logic [CLS_W-1:0] res_class;
  logic [1:0]       res_flags;

  modport master (
    output eng_resetn, eng_start, eng_image_index,
    input  eng_done, eng_predicted_class,
    output res_valid, res_index, res_class, res_flags,
    input  res_ready
  );

  modport slave (
    input  eng_resetn, eng_start, eng_image_index,
    output eng_done, eng_predicted_class,
    input  res_valid, res_index, res_class, res_flags,
    output res_ready
  );
endinterface

// File: rtl/cnn_batch_scheduler.sv
// Runs the CNN engine once per image over [first, last] and streams (index, class) results.
// Optional per-class result histogram is built when CNN_SCHED_HIST_EN is defined.
module cnn_batch_scheduler #(
  parameter int IDX_W          = 5,
  parameter int CLS_W          = 4,
  parameter int NUM_CLASSES    = 9,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [IDX_W-1:0] cfg_first_idx,
  input  logic [IDX_W-1:0] cfg_last_idx,
  input  logic             batch_start,
  input  logic             batch_abort,
  output logic             batch_busy,
  output logic             batch_done,
  output logic [1:0]       batch_status,
`ifdef CNN_SCHED_HIST_EN
  input  logic [3:0]       hist_sel,
  output logic [5:0]       hist_count,
`endif
  cnn_batch_scheduler_if.master bus
);
  localparam logic [3:0]       RST_LAST  = 4'(RST_CYCLES - 1);
  localparam logic [15:0]      WD_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [CLS_W-1:0] CLS_LIMIT = CLS_W'(NUM_CLASSES);
  localparam logic [CLS_W-1:0] CLS_BAD   = '1;
  localparam logic [1:0] ST_OK = 2'd0, ST_CFG = 2'd1, ST_ABORT = 2'd2, ST_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_ENG_RST, S_ENG_GO, S_WAIT_DONE, S_EMIT, S_ABORT_RST, S_FIN
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] cur_idx_reg;
  logic [IDX_W-1:0] last_idx_reg;
  logic [3:0]       rst_cnt_reg;
  logic [15:0]      wd_cnt_reg;
  logic             timeout_seen_reg;
  logic             eng_resetn_reg;
  logic             eng_start_reg;
  logic             res_valid_reg;
  logic [CLS_W-1:0] res_class_reg;
  logic [1:0]       res_flags_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [1:0]       status_reg;

  logic start_ok;
  logic abort_ok;
  logic emit_fire;

  // A second abort during the abort reset would only stretch it, so it is not re-armed there.
  assign start_ok  = (state_reg == S_IDLE) && batch_start;
  assign abort_ok  = busy_reg && batch_abort && (state_reg != S_ABORT_RST);
  assign emit_fire = (state_reg == S_EMIT) && res_valid_reg && bus.res_ready && !abort_ok;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg        <= S_IDLE;
      cur_idx_reg      <= '0;
      last_idx_reg     <= '0;
      rst_cnt_reg      <= '0;
      wd_cnt_reg       <= '0;
      timeout_seen_reg <= 1'b0;
      eng_resetn_reg   <= 1'b0;
      eng_start_reg    <= 1'b0;
      res_valid_reg    <= 1'b0;
      res_class_reg    <= '0;
      res_flags_reg    <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      status_reg       <= '0;
    end else begin
      done_reg      <= 1'b0;
      eng_start_reg <= 1'b0;
      if (abort_ok) begin
        state_reg      <= S_ABORT_RST;
        res_valid_reg  <= 1'b0;
        eng_resetn_reg <= 1'b0;
        rst_cnt_reg    <= '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            eng_resetn_reg <= 1'b1;
            if (batch_start) begin
              last_idx_reg     <= cfg_last_idx;
              timeout_seen_reg <= 1'b0;
              if (cfg_first_idx > cfg_last_idx) begin
                state_reg  <= S_FIN;
                done_reg   <= 1'b1;
                status_reg <= ST_CFG;
              end else begin
                cur_idx_reg    <= cfg_first_idx;
                state_reg      <= S_ENG_RST;
                busy_reg       <= 1'b1;
                eng_resetn_reg <= 1'b0;
                rst_cnt_reg    <= '0;
              end
            end
          end
          S_ENG_RST: begin
            if (rst_cnt_reg == RST_LAST) begin
              state_reg      <= S_ENG_GO;
              eng_resetn_reg <= 1'b1;
              eng_start_reg  <= 1'b1;
            end else begin
              rst_cnt_reg <= rst_cnt_reg + 4'd1;
            end
          end
          S_ENG_GO: begin
            state_reg  <= S_WAIT_DONE;
            wd_cnt_reg <= '0;
          end
          S_WAIT_DONE: begin
            // A done arriving on the last watchdog cycle still counts as a real result.
            if (bus.eng_done) begin
              state_reg     <= S_EMIT;
              res_valid_reg <= 1'b1;
              if (bus.eng_predicted_class >= CLS_LIMIT) begin
                res_class_reg <= CLS_BAD;
                res_flags_reg <= 2'b10;
              end else begin
                res_class_reg <= bus.eng_predicted_class;
                res_flags_reg <= 2'b00;
              end
            end else if (wd_cnt_reg == WD_LAST) begin
              state_reg        <= S_EMIT;
              res_valid_reg    <= 1'b1;
              res_class_reg    <= CLS_BAD;
              res_flags_reg    <= 2'b01;
              timeout_seen_reg <= 1'b1;
            end else begin
              wd_cnt_reg <= wd_cnt_reg + 16'd1;
            end
          end
          S_EMIT: begin
            if (emit_fire) begin
              res_valid_reg <= 1'b0;
              // Compare before incrementing so a batch ending at the top index never wraps.
              if (cur_idx_reg == last_idx_reg) begin
                state_reg  <= S_FIN;
                done_reg   <= 1'b1;
                busy_reg   <= 1'b0;
                status_reg <= timeout_seen_reg ? ST_TIMEOUT : ST_OK;
              end else begin
                cur_idx_reg    <= cur_idx_reg + 1'b1;
                state_reg      <= S_ENG_RST;
                eng_resetn_reg <= 1'b0;
                rst_cnt_reg    <= '0;
              end
            end
          end
          S_ABORT_RST: begin
            if (rst_cnt_reg == RST_LAST) begin
              state_reg      <= S_FIN;
              done_reg       <= 1'b1;
              busy_reg       <= 1'b0;
              status_reg     <= ST_ABORT;
              eng_resetn_reg <= 1'b1;
            end else begin
              rst_cnt_reg <= rst_cnt_reg + 4'd1;
            end
          end
          S_FIN: begin
            state_reg <= S_IDLE;
          end
          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign batch_busy          = busy_reg;
  assign batch_done          = done_reg;
  assign batch_status        = status_reg;
  assign bus.eng_resetn      = eng_resetn_reg;
  assign bus.eng_start       = eng_start_reg;
  assign bus.eng_image_index = cur_idx_reg;
  assign bus.res_valid       = res_valid_reg;
  assign bus.res_index       = cur_idx_reg;
  assign bus.res_class       = res_class_reg;
  assign bus.res_flags       = res_flags_reg;

`ifdef CNN_SCHED_HIST_EN
  localparam logic [3:0] HIST_N = 4'(NUM_CLASSES);

  logic [5:0] hist_vec [NUM_CLASSES];
  logic [5:0] hist_count_reg;

  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_hist
      logic [5:0] cnt_reg;
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          cnt_reg <= '0;
        end else if (start_ok) begin
          cnt_reg <= '0;
        end else if (emit_fire && (res_flags_reg == 2'b00) &&
                     (res_class_reg == CLS_W'(gi)) && (cnt_reg != 6'd63)) begin
          cnt_reg <= cnt_reg + 6'd1;
        end
      end
      assign hist_vec[gi] = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_count_reg <= '0;
    end else begin
      hist_count_reg <= (hist_sel < HIST_N) ? hist_vec[hist_sel] : 6'd0;
    end
  end

  assign hist_count = hist_count_reg;
`endif
endmodule

// File: tb/tb_cnn_batch_scheduler.sv
// Bench for cnn_batch_scheduler: stub engine, transaction-level result model and a per-cycle monitor.
module tb_cnn_batch_scheduler;
  localparam int IDX_W = 5, CLS_W = 4, NUM_CLASSES = 9, RST_CYCLES = 2;
  localparam int TIMEOUT_CYCLES = 16, ENG_LAT = 7;

  logic             clk = 1'b0;
  logic             resetn;
  logic [IDX_W-1:0] cfg_first_idx, cfg_last_idx;
  logic             batch_start, batch_abort;
  logic             batch_busy, batch_done;
  logic [1:0]       batch_status;
`ifdef CNN_SCHED_HIST_EN
  logic [3:0]       hist_sel;
  logic [5:0]       hist_count;
`endif

  cnn_batch_scheduler_if #(.IDX_W(IDX_W), .CLS_W(CLS_W)) bus_if ();

  cnn_batch_scheduler #(
    .IDX_W(IDX_W), .CLS_W(CLS_W), .NUM_CLASSES(NUM_CLASSES),
    .RST_CYCLES(RST_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cfg_first_idx(cfg_first_idx), .cfg_last_idx(cfg_last_idx),
    .batch_start(batch_start), .batch_abort(batch_abort),
    .batch_busy(batch_busy), .batch_done(batch_done), .batch_status(batch_status),
`ifdef CNN_SCHED_HIST_EN
    .hist_sel(hist_sel), .hist_count(hist_count),
`endif
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: expected results of a batch from the rules ----------------
  typedef struct { int idx; int cls; int flags; } res_t;
  res_t exp_q[$];
  int   exp_status = 0;
  int   hang_idx = -1, bad_idx = -1;

  function automatic int eng_class(input int idx);
    return (idx == bad_idx) ? NUM_CLASSES : idx % NUM_CLASSES;
  endfunction

  task automatic build_model(input int first, input int last);
    exp_q.delete();
    exp_status = (first > last) ? 1 : 0;
    for (int i = first; i <= last; i++) begin
      res_t r;
      r.idx = i;
      if (i == hang_idx) begin
        r.cls = 15; r.flags = 1; exp_status = 3;
      end else if (eng_class(i) >= NUM_CLASSES) begin
        r.cls = 15; r.flags = 2;
      end else begin
        r.cls = eng_class(i); r.flags = 0;
      end
      exp_q.push_back(r);
    end
  endtask

  // ---------------- stub engine: done ENG_LAT cycles after start ----------------
  int               stub_cnt = 0;
  logic [IDX_W-1:0] stub_idx = '0;
  initial begin
    bus_if.eng_done = 1'b0;
    bus_if.eng_predicted_class = '0;
    forever begin
      @(posedge clk); #1;
      bus_if.eng_done = 1'b0;
      if (!bus_if.eng_resetn) begin
        stub_cnt = 0;
      end else if (bus_if.eng_start) begin
        stub_idx = bus_if.eng_image_index;
        stub_cnt = (int'(stub_idx) == hang_idx) ? 0 : ENG_LAT;
      end else if (stub_cnt > 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          bus_if.eng_done = 1'b1;
          bus_if.eng_predicted_class = CLS_W'(eng_class(int'(stub_idx)));
        end
      end
    end
  end

  // ---------------- monitor: compares the DUT with the model every cycle ----------------
  int   cyc = 0, low_run = 0, last_run = 0, start_cyc = 0, start_cnt = 0;
  int   done_cnt = 0, done_base = 0, res_cnt = 0, bstart_cyc = 0, done_cyc = 0;
  int   last_status = 0, last_res_idx = -1, abort_cyc = 0;
  int   got_cls [32];
  int   got_flags [32];
  bit   aborted = 1'b0, chk_nonzero = 1'b0, busy_seen = 1'b0;
  logic prev_valid = 1'b0, prev_hs = 1'b0;
  logic [IDX_W-1:0] prev_idx = '0;
  logic [CLS_W-1:0] prev_cls = '0;
  logic [1:0]       prev_flags = '0;
  res_t mon_r;

  always @(negedge clk) begin
    cyc++;
    if (!resetn) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (batch_start) bstart_cyc = cyc;
      if (batch_busy) busy_seen = 1'b1;
      if (chk_nonzero && batch_busy) check("index_nonzero", 32'(bus_if.eng_image_index != 0), 1);

      if (!bus_if.eng_resetn) begin
        low_run++;
        if (batch_busy && exp_q.size() > 0)
          check("rst_index", 32'(bus_if.eng_image_index), 32'(exp_q[0].idx));
      end else begin
        if (low_run > 0) last_run = low_run;
        low_run = 0;
      end

      if (bus_if.eng_start) begin
        start_cnt++;
        start_cyc = cyc;
        check("rst_low_cycles", 32'(last_run), RST_CYCLES);
        check("start_while_pending", 32'(bus_if.res_valid), 0);
        check("start_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0)
          check("start_index", 32'(bus_if.eng_image_index), 32'(exp_q[0].idx));
      end

      if (aborted && cyc > abort_cyc) check("valid_after_abort", 32'(bus_if.res_valid), 0);
      if (prev_valid && !prev_hs && !aborted) check("valid_held", 32'(bus_if.res_valid), 1);

      if (bus_if.res_valid) begin
        if (!prev_valid) begin
          if (exp_q.size() > 0)
            check("valid_latency", 32'(cyc - start_cyc),
                  32'((exp_q[0].flags == 1) ? TIMEOUT_CYCLES + 1 : ENG_LAT + 1));
        end else if (!prev_hs) begin
          check("hold_index", 32'(bus_if.res_index), 32'(prev_idx));
          check("hold_class", 32'(bus_if.res_class), 32'(prev_cls));
          check("hold_flags", 32'(bus_if.res_flags), 32'(prev_flags));
        end
        if (bus_if.res_ready && !batch_abort) begin
          res_cnt++;
          check("result_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            mon_r = exp_q.pop_front();
            check("res_index", 32'(bus_if.res_index), 32'(mon_r.idx));
            check("res_class", 32'(bus_if.res_class), 32'(mon_r.cls));
            check("res_flags", 32'(bus_if.res_flags), 32'(mon_r.flags));
          end
          got_cls[bus_if.res_index]   = int'(bus_if.res_class);
          got_flags[bus_if.res_index] = int'(bus_if.res_flags);
          last_res_idx = int'(bus_if.res_index);
          $display("result idx=%0d class=%0d flags=%0d", bus_if.res_index, bus_if.res_class, bus_if.res_flags);
        end
      end

      if (batch_done) begin
        done_cnt++;
        done_cyc = cyc;
        last_status = int'(batch_status);
        check("batch_status", 32'(batch_status), 32'(exp_status));
        check("results_drained", 32'(exp_q.size()), 0);
        $display("batch_done status=%0d", batch_status);
      end

      prev_valid = bus_if.res_valid;
      prev_hs    = bus_if.res_valid && bus_if.res_ready && !batch_abort;
      prev_idx   = bus_if.res_index;
      prev_cls   = bus_if.res_class;
      prev_flags = bus_if.res_flags;
    end
  end

  // ---------------- stimulus ----------------
  task automatic launch(input int first, input int last, input bit with_abort);
    build_model(first, last);
    @(posedge clk); #1;
    done_base     = done_cnt;
    cfg_first_idx = IDX_W'(first);
    cfg_last_idx  = IDX_W'(last);
    batch_start   = 1'b1;
    batch_abort   = with_abort;
    @(posedge clk); #1;
    batch_start   = 1'b0;
    batch_abort   = 1'b0;
    cfg_first_idx = '0;
    cfg_last_idx  = '1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("done_in_budget", 32'(done_cnt - done_base), 1);
  endtask

  int s0, r0, n;

  initial begin
    resetn = 1'b0;
    cfg_first_idx = '0; cfg_last_idx = '0;
    batch_start = 1'b0; batch_abort = 1'b0;
    bus_if.res_ready = 1'b0;
`ifdef CNN_SCHED_HIST_EN
    hist_sel = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(batch_busy), 0);
    check("rst_done", 32'(batch_done), 0);
    check("rst_status", 32'(batch_status), 0);
    check("rst_eng_resetn", 32'(bus_if.eng_resetn), 0);
    check("rst_eng_start", 32'(bus_if.eng_start), 0);
    check("rst_eng_index", 32'(bus_if.eng_image_index), 0);
    check("rst_res_valid", 32'(bus_if.res_valid), 0);
    check("rst_res_index", 32'(bus_if.res_index), 0);
    check("rst_res_class", 32'(bus_if.res_class), 0);
    check("rst_res_flags", 32'(bus_if.res_flags), 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_eng_resetn", 32'(bus_if.eng_resetn), 1);
    bus_if.res_ready = 1'b1;

    // Full batch 1..20 with a start pulse mid-batch that must be ignored.
    s0 = start_cnt; r0 = res_cnt;
    launch(1, 20, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    cfg_first_idx = '0; cfg_last_idx = '0; batch_start = 1'b1;
    @(posedge clk); #1;
    batch_start = 1'b0;
    wait_done(1000);
    check("t1_results", 32'(res_cnt - r0), 20);
    check("t1_starts", 32'(start_cnt - s0), 20);
    check("t1_idx1_class", 32'(got_cls[1]), 1);
    check("t1_idx9_class", 32'(got_cls[9]), 0);
    check("t1_idx20_class", 32'(got_cls[20]), 2);
    check("t1_status", 32'(last_status), 0);

    // first > last: configuration error, nothing launched.
    s0 = start_cnt; busy_seen = 1'b0;
    launch(5, 3, 1'b0);
    wait_done(20);
    check("t2_no_start", 32'(start_cnt - s0), 0);
    check("t2_done_delay", 32'(done_cyc - bstart_cyc), 1);
    check("t2_busy_low", 32'(busy_seen), 0);
    check("t2_status", 32'(last_status), 1);

    // Single image at the top index, with a simultaneous abort in IDLE that must lose.
    r0 = res_cnt; chk_nonzero = 1'b1;
    launch(31, 31, 1'b1);
    wait_done(200);
    chk_nonzero = 1'b0;
    check("t3_results", 32'(res_cnt - r0), 1);
    check("t3_index", 32'(last_res_idx), 31);
    check("t3_status", 32'(last_status), 0);

    // Engine hangs on index 2.
    hang_idx = 2;
    launch(0, 3, 1'b0);
    wait_done(500);
    hang_idx = -1;
    check("t4_idx2_class", 32'(got_cls[2]), 15);
    check("t4_idx2_flags", 32'(got_flags[2]), 1);
    check("t4_idx3_class", 32'(got_cls[3]), 3);
    check("t4_status", 32'(last_status), 3);

    // Engine returns class 9 (== NUM_CLASSES) for index 7.
    bad_idx = 7;
    launch(6, 8, 1'b0);
    wait_done(500);
    bad_idx = -1;
    check("t4b_idx7_class", 32'(got_cls[7]), 15);
    check("t4b_idx7_flags", 32'(got_flags[7]), 2);
    check("t4b_idx8_class", 32'(got_cls[8]), 8);
    check("t4b_status", 32'(last_status), 0);

    // Backpressure for 10 cycles, then abort in WAIT_DONE of the next image.
    bus_if.res_ready = 1'b0;
    s0 = start_cnt;
    launch(10, 12, 1'b0);
    n = 0;
    while (!bus_if.res_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_valid_seen", 32'(bus_if.res_valid), 1);
    repeat (10) @(posedge clk);
    #1;
    check("t5_starts_stalled", 32'(start_cnt - s0), 1);
    bus_if.res_ready = 1'b1;
    n = 0;
    while (start_cnt - s0 < 2 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_second_start", 32'(start_cnt - s0), 2);
    repeat (3) @(posedge clk);
    #1;
    batch_abort = 1'b1;
    abort_cyc = cyc + 1;
    aborted = 1'b1;
    exp_q.delete();
    exp_status = 2;
    @(posedge clk); #1;
    batch_abort = 1'b0;
    @(negedge clk);
    check("t5_abort_rst1", 32'(bus_if.eng_resetn), 0);
    check("t5_abort_valid", 32'(bus_if.res_valid), 0);
    @(negedge clk);
    check("t5_abort_rst2", 32'(bus_if.eng_resetn), 0);
    @(negedge clk);
    check("t5_abort_done", 32'(batch_done), 1);
    check("t5_abort_status", 32'(batch_status), 2);
    repeat (20) @(posedge clk);
    #1;
    aborted = 1'b0;
    check("t5_done_count", 32'(done_cnt - done_base), 1);
    check("t5_starts_total", 32'(start_cnt - s0), 2);

`ifdef CNN_SCHED_HIST_EN
    launch(0, 17, 1'b0);
    wait_done(1000);
    for (int s = 0; s < 16; s++) begin
      hist_sel = 4'(s);
      @(posedge clk); #1;
      check("hist_count", 32'(hist_count), (s < NUM_CLASSES) ? 2 : 0);
    end
    launch(5, 3, 1'b0);
    wait_done(20);
    hist_sel = 4'd0;
    @(posedge clk); #1;
    check("hist_cleared0", 32'(hist_count), 0);
    hist_sel = 4'd8;
    @(posedge clk); #1;
    check("hist_cleared8", 32'(hist_count), 0);
`endif

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/cnn_batch_scheduler.md
Name: cnn_batch_scheduler

Overview:
Sequences CNN_Accelerator_Engine over a programmable range of stored image indices, one inference per image. For each image it soft-resets the engine, pulses start, waits for done, and emits an (index, class) result on a valid/ready stream. A watchdog guards each inference. The block sits between the host/control register file and the engine, so software no longer hand-drives resetn/start per image.

Parameters:
IDX_W, 5, image index width; matches engine input_image_index.
CLS_W, 4, class width; matches engine predicted_class.
NUM_CLASSES, 9, number of valid classes (0..8); class 8 is NONE.
RST_CYCLES, 2, cycles eng_resetn is held low before each start; legal range 1..15.
TIMEOUT_CYCLES, 65535, WAIT_DONE cycles before an inference is declared hung; counter is 16 bits.

Ports:
clk  in  1  system clock.
resetn  in  1  asynchronous active-low reset.
cfg_first_idx  in  IDX_W  first image index; sampled on an accepted batch_start.
cfg_last_idx  in  IDX_W  last image index, inclusive; sampled on an accepted batch_start.
batch_start  in  1  single-cycle request to run a batch.
batch_abort  in  1  stops the current batch.
batch_busy  out  1  high from an accepted start until batch_done.
batch_done  out  1  one-cycle pulse at batch end.
batch_status  out  2  valid with batch_done: 0=ok, 1=cfg error, 2=aborted, 3=one or more timeouts.
eng_resetn  out  1  engine soft reset, active-low.
eng_start  out  1  engine start pulse.
eng_image_index  out  IDX_W  index presented to the engine.
eng_done  in  1  engine completion.
eng_predicted_class  in  CLS_W  engine result.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts the result.
res_index  out  IDX_W  image index of the result.
res_class  out  CLS_W  class, or 4'hF on timeout or bad class.
res_flags  out  2  bit0 = timeout, bit1 = class >= NUM_CLASSES.

Behaviour:
- Reset values: all outputs 0, except eng_resetn=0 (engine held in reset while the scheduler is in reset). State is IDLE.
- IDLE: eng_resetn=1. batch_start latches cfg_first_idx and cfg_last_idx, then:
  - first > last: go to FIN with status 1, emit no results.
  - otherwise: cur_idx=first, go to ENG_RST, batch_busy=1 from the next cycle.
- ENG_RST: eng_resetn=0 for exactly RST_CYCLES cycles, with eng_image_index=cur_idx stable. Then go to ENG_GO.
- ENG_GO: eng_resetn=1, eng_start=1 for exactly one cycle. Then go to WAIT_DONE and clear the watchdog.
- WAIT_DONE:
  - eng_done=1: capture eng_predicted_class. If the class is >= NUM_CLASSES, res_class=4'hF and flags=2'b10. Go to EMIT.
  - Watchdog reaches TIMEOUT_CYCLES with no done: res_class=4'hF, flags=2'b01, set the sticky timeout bit, go to EMIT.
  - eng_done is ignored in every other state.
- EMIT: res_valid=1 with res_index/res_class/res_flags stable until res_valid && res_ready. On the handshake:
  - cur_idx==last: go to FIN.
  - otherwise: cur_idx+1, go to ENG_RST.
  - The equality compare happens before the increment, so last=31 never wraps the index.
- Latency: one inference costs RST_CYCLES+1+engine latency+1 cycles, plus backpressure.
- FIN: batch_done=1 for one cycle with batch_status. Status 3 if any timeout occurred, otherwise 0 (or 1/2 as set). Clear batch_busy, go to IDLE.
- batch_start while busy: ignored, no latch update.
- batch_abort while busy, in any state: res_valid drops next cycle and any pending result is discarded. eng_resetn is driven 0 for RST_CYCLES, then go to FIN with status 2. Abort wins over a simultaneous eng_done or handshake.
- batch_abort in IDLE: ignored.
- batch_start and batch_abort in the same IDLE cycle: start wins.
- Asynchronous reset mid-batch: immediate return to reset values. No batch_done is produced.

Optional Feature:
CNN_SCHED_HIST_EN.
- Defined: adds input hist_sel[3:0] and output hist_count[5:0].
  - Per-class saturating counters (one per class 0..NUM_CLASSES-1, saturate at 63) increment on each EMIT handshake that carries a valid class; flagged results are not counted.
  - Counters clear on an accepted batch_start.
  - hist_count is a registered read of counter hist_sel, one-cycle latency; hist_sel out of range reads 0.
- Undefined: no ports and no counters; all other behaviour is identical.

Test Plan:
- first=1, last=20, res_ready=1, stub engine returns class = idx mod 9 after 7 cycles -> 20 results in order. Index 1 carries class 1 and index 9 carries class 0. eng_resetn goes low for 2 cycles before every eng_start. batch_done fires with status 0.
- first=5, last=3 -> no eng_start, batch_done one cycle after start with status 1, batch_busy stays 0.
- first=last=31 -> exactly one result, index 31, then FIN. eng_image_index never shows 0.
- Stub never asserts done for index 2 of range 0..3, TIMEOUT_CYCLES=16 -> index 2 returns class 4'hF with flags 01 at WAIT_DONE cycle 16. Indices 3.. continue. Status 3.
- res_ready held low for 10 cycles during EMIT -> res_* stable throughout, no next eng_start until the handshake. Then assert abort in WAIT_DONE -> eng_resetn low, batch_done with status 2, no further res_valid.
- Build with CNN_SCHED_HIST_EN, range 0..17, class = idx mod 9 -> hist_count=2 for sel 0..8, 0 for sel 9..15. A new batch_start clears all counts.
